moore_1100: RTL and testbench

MOORE_1100 -- requirements
Module: moore_1100

---
 rtl/moore_1100.sv | 48 ++++
 tb/tb_moore_1100.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/moore_1100.sv
// Moore detector for the serial pattern 1100 (first-received bit first).
// z is a registered flag that is high for exactly one state period while in S4.
module moore_1100 (
  input  logic clk,
  input  logic reset,
  input  logic x,
  output logic z
);

  typedef enum logic [2:0] {
    S0 = 3'd0,  // idle / no match
    S1 = 3'd1,  // seen "1"
    S2 = 3'd2,  // seen "11"
    S3 = 3'd3,  // seen "110"
    S4 = 3'd4   // seen "1100": detect
  } state_e;

  state_e state_q, state_d;
  logic   z_q;

  // Encodings 5-7 are not enum members; the default arm returns them to S0.
  always_comb begin
    state_d = S0;
    case (state_q)
      S0:      state_d = x ? S1 : S0;
      S1:      state_d = x ? S2 : S0;
      S2:      state_d = x ? S2 : S3;
      S3:      state_d = x ? S1 : S4;
      S4:      state_d = x ? S1 : S0;
      default: state_d = S0;
    endcase
  end

  // z_q is loaded from the next state, so it always equals (state_q == S4)
  // without any path from x to z between edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      z_q     <= (state_d == S4);
    end
  end

  assign z = z_q;

endmodule

// File: tb/tb_moore_1100.sv
// Scoreboard bench for moore_1100: a driver pushes the expected z for every edge,
// a monitor pops and compares one time unit after each rising edge.
module tb_moore_1100;

  logic clk;
  logic reset;
  logic x;
  logic z;

  moore_1100 dut (
    .clk   (clk),
    .reset (reset),
    .x     (x),
    .z     (z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string name;
    logic  exp;
  } exp_t;

  exp_t  sb_q[$];
  int    total = 0;
  int    bad   = 0;
  bit    hist[$];     // bits sampled since the last reset, newest last
  logic  last_exp = 1'b0;

  // Reference: z after an edge is 1 iff the last four bits since reset are 1,1,0,0.
  function automatic logic model_edge(input bit r, input bit xv);
    if (r) begin
      hist.delete();
      return 1'b0;
    end
    hist.push_back(xv);
    if (hist.size() > 4) void'(hist.pop_front());
    if (hist.size() < 4) return 1'b0;
    return (hist[0] == 1'b1) && (hist[1] == 1'b1) && (hist[2] == 1'b0) && (hist[3] == 1'b0);
  endfunction

  task automatic step(input bit r, input bit xv, input string name);
    exp_t e;
    @(negedge clk);
    reset = r;
    x     = xv;
    @(posedge clk);
    e.name   = name;
    e.exp    = model_edge(r, xv);
    last_exp = e.exp;
    sb_q.push_back(e);
  endtask

  // Reset pulses between edges must not disturb state or z.
  task automatic glitch_step(input bit xv, input string name);
    exp_t e;
    @(negedge clk);
    reset = 1'b0;
    x     = xv;
    #1 reset = 1'b1;
    #1;
    total++;
    if (z !== last_exp) begin
      bad++;
      $display("FAIL %s_midcycle: z=%0b expected=%0b", name, z, last_exp);
    end
    reset = 1'b0;
    @(posedge clk);
    e.name   = name;
    e.exp    = model_edge(1'b0, xv);
    last_exp = e.exp;
    sb_q.push_back(e);
  endtask

  task automatic seq(input string bits, input string name);
    for (int unsigned i = 0; i < bits.len(); i++)
      step(1'b0, bits[i] == "1", name);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        total++;
        if (z !== e.exp) begin
          bad++;
          $display("FAIL %s: z=%0b expected=%0b at %0t", e.name, z, e.exp, $time);
        end
      end
    end
  end

  initial begin
    int unsigned wait_cycles;
    reset = 1'b1;
    x     = 1'b0;

    step(1'b1, 1'b0, "reset");
    seq("1100", "basic_1100");
    seq("0", "after_detect");
    step(1'b1, 1'b0, "reset2");
    seq("11001100", "back_to_back");
    seq("00", "idle");
    seq("111100", "s2_selfloop");
    seq("0", "idle2");
    seq("1101100", "overlap_1101100");
    seq("0", "idle3");
    seq("110", "partial");
    step(1'b1, 1'b0, "reset_midseq");
    seq("0", "after_reset_x0");
    seq("0011", "fresh_start");
    step(1'b1, 1'b1, "reset_ignores_x");
    seq("100", "fresh_after_reset");
    seq("11", "pre_glitch");
    glitch_step(1'b0, "glitch_s3");
    glitch_step(1'b0, "glitch_s4");
    glitch_step(1'b1, "glitch_s1");

    for (int unsigned i = 0; i < 800; i++) begin
      if ($urandom_range(0, 39) == 0)
        step(1'b1, 1'($urandom_range(0, 1)), "rand_reset");
      else if ($urandom_range(0, 9) == 0)
        seq("1100", "rand_pattern");
      else
        step(1'b0, 1'($urandom_range(0, 1)), "rand_bit");
    end

    wait_cycles = 0;
    while (sb_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    if (sb_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: pending=%0d expected=0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
